// File: rtl/wb_trace_buffer.sv
// Commit-trace FWFT queue behind the write-back stage; overflow is counted, never stalled.
// Optional per-entry cycle timestamp: define WB_TRACE_TIMESTAMP_EN.
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNTW  = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         WBValid,
  input  logic [4:0]                   WBReg,
  input  logic [31:0]                  WBData,
  input  logic [31:0]                  WBPC,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [31:0]                  OutPC,
  output logic [4:0]                   OutReg,
  output logic [31:0]                  OutData,
  output logic [31:0]                  OutTS,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overflow,
  output logic [CNTW-1:0]              DropCount,
  input  logic                         ClearFlags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0] pc_mem   [DEPTH];
  logic [4:0]  reg_mem  [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [CNTW-1:0] drop_q, drop_d;
  logic            full, push, pop, drop;

  assign full     = (count_q == CW'(DEPTH));
  assign OutValid = (count_q != '0);
  assign pop      = OutValid && OutReady;
  assign push     = WBValid && (!full || pop);
  assign drop     = WBValid && !push;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A clear in the same cycle as a drop wins; that drop is not counted.
    if (ClearFlags) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CNTW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is intentionally left uninitialised by reset.
  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem[wp_q]   <= WBPC;
      reg_mem[wp_q]  <= WBReg;
      data_mem[wp_q] <= WBData;
    end
  end

  assign OutPC     = pc_mem[rp_q];
  assign OutReg    = reg_mem[rp_q];
  assign OutData   = data_mem[rp_q];
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign DropCount = drop_q;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] ts_mem [DEPTH];
  logic [31:0] ts_q;

  always_ff @(posedge Clk) begin
    if (Reset) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (push) ts_mem[wp_q] <= ts_q;
  end

  assign OutTS = ts_mem[rp_q];
`else
  assign OutTS = 32'h0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: queue-based reference model plus directed corner cases.
module tb_wb_trace_buffer;
  localparam int DEPTH = 16;
  localparam int CNTW  = 16;

  logic        Clk = 1'b0;
  logic        Reset, WBValid, OutReady, ClearFlags;
  logic [4:0]  WBReg;
  logic [31:0] WBData, WBPC;
  logic        OutValid, Overflow;
  logic [31:0] OutPC, OutData, OutTS;
  logic [4:0]  OutReg;
  logic [$clog2(DEPTH+1)-1:0] Count;
  logic [CNTW-1:0] DropCount;

  always #5 Clk = ~Clk;

  wb_trace_buffer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .Clk(Clk), .Reset(Reset), .WBValid(WBValid), .WBReg(WBReg), .WBData(WBData),
    .WBPC(WBPC), .OutValid(OutValid), .OutReady(OutReady), .OutPC(OutPC),
    .OutReg(OutReg), .OutData(OutData), .OutTS(OutTS), .Count(Count),
    .Overflow(Overflow), .DropCount(DropCount), .ClearFlags(ClearFlags)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] d;
    logic [31:0] ts;
  } ent_t;

  ent_t        exp_q[$];
  int          mcount = 0;
  bit          movf = 0;
  int unsigned mdrops = 0;
  logic [31:0] mts = 0;
  bit          mon_en = 0;
  int          n_checks = 0;
  int          n_fail = 0;

`ifdef WB_TRACE_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue with a size limit, a drop tally and a cycle counter.
  always @(posedge Clk) begin
    bit pop, push, drop;
    if (Reset) begin
      mcount = 0;
      movf   = 0;
      mdrops = 0;
      mts    = 0;
      exp_q.delete();
    end else begin
      pop  = (mcount != 0) && OutReady;
      push = WBValid && ((mcount < DEPTH) || pop);
      drop = WBValid && !push;
      if (push) exp_q.push_back('{WBPC, WBReg, WBData, TS_ON ? mts : 32'h0});
      mcount = mcount + int'(push) - int'(pop);
      if (ClearFlags) begin
        movf   = 0;
        mdrops = 0;
      end else if (drop) begin
        movf = 1;
        if (mdrops < 65535) mdrops++;
      end
      mts = mts + 32'd1;
    end
  end

  // Monitor: status every cycle, entry contents whenever the head is accepted.
  always @(negedge Clk) begin
    ent_t e;
    if (mon_en) begin
      chk("count", Count, mcount);
      chk("out_valid", OutValid, mcount != 0);
      chk("overflow", Overflow, movf);
      chk("drop_count", DropCount, mdrops);
      if (OutValid && OutReady && !Reset) begin
        if (exp_q.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", OutPC, e.pc);
          chk("out_reg", OutReg, e.rg);
          chk("out_data", OutData, e.d);
          chk("out_ts", OutTS, e.ts);
        end
      end
    end
  end

  task automatic step(input bit rst, input bit v, input logic [4:0] r, input logic [31:0] d,
                      input logic [31:0] pc, input bit rdy, input bit clr);
    Reset = rst; WBValid = v; WBReg = r; WBData = d; WBPC = pc;
    OutReady = rdy; ClearFlags = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic rstep(input bit v, input bit rdy, input bit clr);
    step(1'b0, v, 5'($urandom), $urandom, $urandom, rdy, clr);
  endtask

  logic [31:0] first_pc;

  initial begin
    Reset = 1'b1; WBValid = 1'b0; WBReg = '0; WBData = '0; WBPC = '0;
    OutReady = 1'b0; ClearFlags = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    mon_en = 1;
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_count", Count, 0);
    chk("rst_valid", OutValid, 0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_drop", DropCount, 0);

    // Single capture in the first cycle after reset, then pop it.
    step(0, 1, 5'd5, 32'h1234, 32'h8, 0, 0);
    chk("single_valid", OutValid, 1);
    chk("single_pc", OutPC, 32'h8);
    chk("single_reg", OutReg, 5);
    chk("single_data", OutData, 32'h1234);
    chk("single_ts", OutTS, 0);
    chk("single_count", Count, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("single_pop_count", Count, 0);
    chk("single_pop_valid", OutValid, 0);

    // Capture ten cycles after the first one; $zero destination still retires.
    for (int i = 0; i < 8; i++) rstep(0, 0, 0);
    step(0, 1, 5'd0, 32'hCAFE, 32'h40, 0, 0);
    chk("ts10", OutTS, TS_ON ? 32'd10 : 32'd0);
    chk("reg_zero", OutReg, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Fill to DEPTH, then overflow by three.
    first_pc = $urandom;
    step(0, 1, 5'($urandom), $urandom, first_pc, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) rstep(1, 0, 0);
    chk("fill_count", Count, DEPTH);
    chk("fill_overflow", Overflow, 0);
    for (int i = 0; i < 3; i++) rstep(1, 0, 0);
    chk("ovf_flag", Overflow, 1);
    chk("ovf_drops", DropCount, 3);
    chk("ovf_head", OutPC, first_pc);

    // Full with simultaneous push and pop: no drop, count holds.
    rstep(1, 1, 0);
    chk("fullpp_count", Count, DEPTH);
    chk("fullpp_drops", DropCount, 3);
    for (int i = 0; i < DEPTH; i++) rstep(0, 1, 0);
    chk("drain_count", Count, 0);

    // Interleaved traffic across pointer wrap, then broader random traffic.
    for (int i = 0; i < 40; i++) rstep(1, $urandom_range(0, 3) != 0, 0);
    for (int i = 0; i < 400; i++)
      rstep($urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);

    for (int i = 0; i < 40 && OutValid; i++) rstep(0, 1, 0);
    chk("drain_empty", OutValid, 0);

    // Drop and clear in the same cycle.
    for (int i = 0; i < DEPTH; i++) rstep(1, 0, 0);
    rstep(1, 0, 1);
    chk("clr_overflow", Overflow, 0);
    chk("clr_drops", DropCount, 0);
    chk("clr_count", Count, DEPTH);

    // Saturate the drop counter.
    for (int i = 0; i < 65536 + 4; i++) rstep(1, 0, 0);
    chk("sat_drops", DropCount, 16'hFFFF);
    chk("sat_overflow", Overflow, 1);

    // Reset with seven entries pending discards them.
    for (int i = 0; i < DEPTH - 7; i++) rstep(0, 1, 0);
    chk("pre_rst_count", Count, 7);
    step(1, 1, 5'd3, 32'h77, 32'h99, 1, 0);
    chk("mid_rst_count", Count, 0);
    chk("mid_rst_valid", OutValid, 0);
    chk("mid_rst_overflow", Overflow, 0);
    step(0, 1, 5'd9, 32'hABCD, 32'h100, 0, 0);
    chk("post_rst_ts", OutTS, 0);
    chk("post_rst_pc", OutPC, 32'h100);
    for (int i = 0; i < 3; i++) rstep(0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
